// File: rtl/hs_pkg.sv
// Shared constants and helpers for the we/next handshake family of blocks.
package hs_pkg;

  localparam int HS_DATA_W = 8;
  localparam int HS_DEPTH  = 4;

  // Ceiling log2 usable in parameter expressions; hs_clog2(1) == 0.
  function automatic int hs_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hs_fifo_mem.sv
// DEPTH x DATA_W storage for hs_fifo: synchronous write, asynchronous read, no reset.
module hs_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/hs_fifo.sv
// Elastic we/next buffer with first-word-fall-through head and level/almost-full status.
// Optional push/pop counters are enabled with the HS_FIFO_STATS_EN macro.
module hs_fifo
  import hs_pkg::*;
#(
  parameter int DATA_W    = HS_DATA_W,
  parameter int DEPTH     = HS_DEPTH,
  parameter int AFULL_LVL = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ai_we,
  output logic                        ao_next,
  input  logic [DATA_W-1:0]           ai_data,
  output logic                        ao_we,
  input  logic                        ai_next,
  output logic [DATA_W-1:0]           ao_data,
  output logic [hs_clog2(DEPTH):0]    ao_level,
  output logic                        ao_afull
`ifdef HS_FIFO_STATS_EN
  ,
  output logic [15:0]                 ao_push_cnt,
  output logic [15:0]                 ao_pop_cnt
`endif
);

  localparam int PTR_W = hs_clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AFULL_LEVEL = LVL_W'(AFULL_LVL);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             push;
  logic             pop;

  // Handshake: a word transfers on a rising edge where the sender's we and the
  // receiver's next are both 1. Each side's output comes only from registered
  // level (plus reset), never from the other side's input, so a full buffer
  // refuses a push even on an edge where it also pops.
  assign ao_next = rst && (level != FULL_LEVEL);
  assign ao_we   = (level != '0);
  assign push    = ai_we && ao_next;
  assign pop     = ao_we && ai_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign ao_level = level;
  assign ao_afull = (level >= AFULL_LEVEL);

  hs_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_addr (wr_ptr),
    .wr_data (ai_data),
    .rd_addr (rd_ptr),
    .rd_data (ao_data)
  );

`ifdef HS_FIFO_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ao_push_cnt <= '0;
      ao_pop_cnt  <= '0;
    end else begin
      if (push) ao_push_cnt <= ao_push_cnt + 16'd1;
      if (pop)  ao_pop_cnt  <= ao_pop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hs_fifo.sv
// Directed self-checking bench for hs_fifo (default DATA_W=8, DEPTH=4, AFULL_LVL=3).
module tb_hs_fifo;

  logic       clk;
  logic       rst;
  logic       ai_we;
  logic       ao_next;
  logic [7:0] ai_data;
  logic       ao_we;
  logic       ai_next;
  logic [7:0] ao_data;
  logic [2:0] ao_level;
  logic       ao_afull;
`ifdef HS_FIFO_STATS_EN
  logic [15:0] ao_push_cnt;
  logic [15:0] ao_pop_cnt;
`endif

  int checks;
  int errors;
  logic [7:0] exp_q[$];

  hs_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .ai_we    (ai_we),
    .ao_next  (ao_next),
    .ai_data  (ai_data),
    .ao_we    (ao_we),
    .ai_next  (ai_next),
    .ao_data  (ao_data),
    .ao_level (ao_level),
    .ao_afull (ao_afull)
`ifdef HS_FIFO_STATS_EN
    ,
    .ao_push_cnt (ao_push_cnt),
    .ao_pop_cnt  (ao_pop_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ai_we = 1'b0; ai_next = 1'b0; ai_data = 8'h00;
    #12;
    checks++; if (ao_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", ao_we); end
    checks++; if (ao_next !== 1'b0) begin errors++; $display("FAIL reset_next got %b want 0", ao_next); end
    checks++; if (ao_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", ao_level); end
    checks++; if (ao_afull !== 1'b0) begin errors++; $display("FAIL reset_afull got %b want 0", ao_afull); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (ao_next !== 1'b1) begin errors++; $display("FAIL idle_next got %b want 1", ao_next); end
    checks++; if (ao_we !== 1'b0) begin errors++; $display("FAIL idle_we got %b want 0", ao_we); end
    ai_next = 1'b1;
    tick();
    tick();
    checks++; if (ao_level !== 3'd0) begin errors++; $display("FAIL idle_pop_level got %0d want 0", ao_level); end
    checks++; if (ao_we !== 1'b0) begin errors++; $display("FAIL idle_pop_we got %b want 0", ao_we); end
    ai_next = 1'b0;
  endtask

  task automatic test_fill();
    logic [2:0] exp_lvl;
    ai_next = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ai_we = 1'b1;
      ai_data = 8'(88 + i);
      tick();
      exp_lvl = 3'(i + 1);
      checks++; if (ao_level !== exp_lvl) begin errors++; $display("FAIL fill_level got %0d want %0d", ao_level, exp_lvl); end
      checks++; if (ao_afull !== (exp_lvl >= 3'd3)) begin errors++; $display("FAIL fill_afull got %b at level %0d", ao_afull, exp_lvl); end
      checks++; if (ao_next !== (exp_lvl != 3'd4)) begin errors++; $display("FAIL fill_next got %b at level %0d", ao_next, exp_lvl); end
      checks++; if (ao_data !== 8'd88) begin errors++; $display("FAIL fill_head got %0d want 88", ao_data); end
    end
    ai_data = 8'd92;
    tick();
    checks++; if (ao_level !== 3'd4) begin errors++; $display("FAIL full_reject_level got %0d want 4", ao_level); end
    checks++; if (ao_data !== 8'd88) begin errors++; $display("FAIL full_reject_head got %0d want 88", ao_data); end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_d [4];
    exp_d = '{8'd89, 8'd90, 8'd91, 8'd92};
    ai_we = 1'b1; ai_data = 8'd92; ai_next = 1'b1;
    #1;
    checks++; if (ao_next !== 1'b0) begin errors++; $display("FAIL full_pop_next_edge got %b want 0", ao_next); end
    checks++; if (ao_data !== 8'd88) begin errors++; $display("FAIL full_pop_data got %0d want 88", ao_data); end
    tick();
    ai_next = 1'b0;
    checks++; if (ao_level !== 3'd3) begin errors++; $display("FAIL full_pop_level got %0d want 3", ao_level); end
    checks++; if (ao_next !== 1'b1) begin errors++; $display("FAIL full_pop_next_after got %b want 1", ao_next); end
    checks++; if (ao_data !== 8'd89) begin errors++; $display("FAIL full_pop_head got %0d want 89", ao_data); end
    tick();
    ai_we = 1'b0;
    checks++; if (ao_level !== 3'd4) begin errors++; $display("FAIL refill_level got %0d want 4", ao_level); end
    ai_next = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ao_data !== exp_d[i]) begin errors++; $display("FAIL drain_data got %0d want %0d", ao_data, exp_d[i]); end
      tick();
    end
    ai_next = 1'b0;
    checks++; if (ao_level !== 3'd0) begin errors++; $display("FAIL drain_level got %0d want 0", ao_level); end
    checks++; if (ao_we !== 1'b0) begin errors++; $display("FAIL drain_we got %b want 0", ao_we); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    exp_q.delete();
    ai_next = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ai_we = 1'b1; ai_data = 8'(i);
      exp_q.push_back(8'(i));
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      ai_we = 1'b1; ai_next = 1'b1; ai_data = 8'(2 + k);
      exp = exp_q.pop_front();
      exp_q.push_back(8'(2 + k));
      checks++; if (ao_data !== exp) begin errors++; $display("FAIL b2b_data got %0d want %0d", ao_data, exp); end
      tick();
      checks++; if (ao_level !== 3'd2) begin errors++; $display("FAIL b2b_level got %0d want 2", ao_level); end
    end
    ai_we = 1'b0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      checks++; if (ao_data !== exp) begin errors++; $display("FAIL b2b_drain got %0d want %0d", ao_data, exp); end
      tick();
    end
    ai_next = 1'b0;
    checks++; if (ao_level !== 3'd0) begin errors++; $display("FAIL b2b_end_level got %0d want 0", ao_level); end
  endtask

  task automatic test_random();
    int  model_level;
    bit  push, pop;
    logic [7:0] exp;
    exp_q.delete();
    model_level = 0;
    ai_we = 1'b0; ai_next = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (!ai_we && $urandom_range(0, 19) < 8) begin
        ai_we = 1'b1;
        ai_data = 8'($urandom_range(0, 255));
      end
      ai_next = ($urandom_range(0, 2) == 0);
      #1;
      checks++; if (ao_level !== 3'(model_level) || ao_level > 3'd4) begin errors++; $display("FAIL rnd_level got %0d want %0d", ao_level, model_level); end
      checks++; if (ao_next !== (model_level != 4)) begin errors++; $display("FAIL rnd_next got %b at level %0d", ao_next, model_level); end
      checks++; if (ao_we !== (model_level != 0)) begin errors++; $display("FAIL rnd_we got %b at level %0d", ao_we, model_level); end
`ifdef HS_FIFO_STATS_EN
      checks++; if (ao_push_cnt - ao_pop_cnt !== 16'(model_level)) begin errors++; $display("FAIL rnd_stats diff %0d want %0d", 16'(ao_push_cnt - ao_pop_cnt), model_level); end
`endif
      push = ai_we && (model_level != 4);
      pop  = ai_next && (model_level != 0);
      if (pop) begin
        exp = exp_q.pop_front();
        checks++; if (ao_data !== exp) begin errors++; $display("FAIL rnd_data got %0d want %0d", ao_data, exp); end
      end
      if (push) exp_q.push_back(ai_data);
      model_level = model_level + int'(push) - int'(pop);
      tick();
      if (push) ai_we = 1'b0;
    end
    ai_we = 1'b0; ai_next = 1'b1;
    for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
      exp = exp_q.pop_front();
      checks++; if (ao_data !== exp) begin errors++; $display("FAIL rnd_drain got %0d want %0d", ao_data, exp); end
      tick();
    end
    ai_next = 1'b0;
    checks++; if (ao_level !== 3'd0 || exp_q.size() != 0) begin errors++; $display("FAIL rnd_end level %0d queue %0d want 0 0", ao_level, exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    ai_next = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      ai_we = 1'b1; ai_data = 8'(i);
      tick();
    end
    ai_we = 1'b0;
    checks++; if (ao_level !== 3'd3) begin errors++; $display("FAIL mid_pre_level got %0d want 3", ao_level); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (ao_we !== 1'b0) begin errors++; $display("FAIL mid_rst_we got %b want 0", ao_we); end
    checks++; if (ao_next !== 1'b0) begin errors++; $display("FAIL mid_rst_next got %b want 0", ao_next); end
    checks++; if (ao_level !== 3'd0) begin errors++; $display("FAIL mid_rst_level got %0d want 0", ao_level); end
`ifdef HS_FIFO_STATS_EN
    checks++; if (ao_push_cnt !== 16'd0 || ao_pop_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_stats got %0d %0d want 0 0", ao_push_cnt, ao_pop_cnt); end
`endif
    tick();
    rst = 1'b1;
    tick();
    ai_we = 1'b1; ai_data = 8'd7;
    tick();
    ai_we = 1'b0;
    checks++; if (ao_we !== 1'b1 || ao_data !== 8'd7) begin errors++; $display("FAIL mid_first got we %b data %0d want 1 7", ao_we, ao_data); end
    ai_next = 1'b1;
    tick();
    ai_next = 1'b0;
    checks++; if (ao_level !== 3'd0) begin errors++; $display("FAIL mid_pop_level got %0d want 0", ao_level); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill();
    test_full_pop();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
